// File: rtl/vga_fetch.sv
// Read-side client of the SRAM arbiter's VGA port: issues credit-limited word
// reads, buffers returns in a small FIFO and unpacks each word into two pixels.
module vga_fetch #(
  parameter int unsigned MEM_WIDTH       = 36,
  parameter int unsigned PIX_WIDTH       = 18,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned WORDS_PER_FRAME = 153600
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               frame_start,
  output logic                               vga_flag,
  input  logic                               done_vga,
  input  logic [MEM_WIDTH-1:0]               vga_pixel,
  input  logic                               pix_req,
  output logic [PIX_WIDTH-1:0]               pixel_out,
  output logic                               pixel_valid,
  output logic                               underflow,
  output logic                               frame_fetched,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [LW:0]   DEPTH_L = FIFO_DEPTH[LW:0];
  localparam logic [WW-1:0] WORDS_L = WORDS_PER_FRAME[WW-1:0];

  logic [MEM_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d, inflight_q, inflight_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [WW-1:0]           words_left_q, words_left_d;
  logic                    half_q, half_d;
  logic [PIX_WIDTH-1:0]    pix_q, pix_d;
  logic                    valid_q, valid_d;
  logic                    under_q, under_d;
  logic                    fetched_q, fetched_d;

  logic [LW:0]          credit_sum;
  logic                 req, grant, push, empty, serve, pop, wr_en;
  logic [MEM_WIDTH-1:0] head;

  always_comb begin
    credit_sum = {1'b0, level_q} + {1'b0, inflight_q};
    req   = !reset && !frame_start && (words_left_q != '0) && (credit_sum < DEPTH_L);
    grant = req && done_vga;
    push  = pipe_q[READ_LATENCY-1];
    empty = (level_q == '0);
    serve = pix_req && !empty;
    pop   = serve && half_q;
    wr_en = push && !frame_start;
    head  = mem_q[rd_ptr_q];

    pipe_d[0] = grant;
    for (int unsigned i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    inflight_d   = inflight_q + LW'(grant) - LW'(push);
    level_d      = level_q + LW'(push) - LW'(pop);
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    words_left_d = grant ? words_left_q - WW'(1) : words_left_q;
    half_d       = serve ? ~half_q : half_q;
    valid_d      = pix_req;
    under_d      = under_q | (pix_req && empty);
    fetched_d    = fetched_q | (words_left_d == '0);

    pix_d = pix_q;
    if (serve)        pix_d = half_q ? head[PIX_WIDTH-1:0] : head[MEM_WIDTH-1:PIX_WIDTH];
    else if (pix_req) pix_d = '0;

    // Frame boundary discards buffered and in-flight words; pixel_out keeps its value.
    if (frame_start) begin
      pipe_d       = '0;
      inflight_d   = '0;
      level_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      half_d       = 1'b0;
      under_d      = 1'b0;
      valid_d      = 1'b0;
      fetched_d    = 1'b0;
      words_left_d = WORDS_L;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_q       <= '0;
      inflight_q   <= '0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      half_q       <= 1'b0;
      under_q      <= 1'b0;
      valid_q      <= 1'b0;
      fetched_q    <= 1'b0;
      words_left_q <= WORDS_L;
      pix_q        <= '0;
    end else begin
      pipe_q       <= pipe_d;
      inflight_q   <= inflight_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      half_q       <= half_d;
      under_q      <= under_d;
      valid_q      <= valid_d;
      fetched_q    <= fetched_d;
      words_left_q <= words_left_d;
      pix_q        <= pix_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= vga_pixel;
  end

  assign vga_flag      = req;
  assign pixel_out     = pix_q;
  assign pixel_valid   = valid_q;
  assign underflow     = under_q;
  assign frame_fetched = fetched_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_vga_fetch.sv
// Scoreboard bench for vga_fetch: directed stimulus, a two-cycle SRAM model,
// and a monitor that checks every pixel_valid against a queue of expected pixels.
module tb_vga_fetch;

  logic        clock, reset, frame_start, vga_flag, done_vga, pix_req;
  logic [35:0] vga_pixel;
  logic [17:0] pixel_out;
  logic        pixel_valid, underflow, frame_fetched;
  logic [3:0]  fifo_level;

  int unsigned total = 0, bad = 0;
  int unsigned gcount = 0, a_cnt = 0, pix_seen = 0, idx = 0;
  logic [35:0] s0 = '1, s1 = '1;
  logic [17:0] expq[$];

  vga_fetch #(.MEM_WIDTH(36), .PIX_WIDTH(18), .READ_LATENCY(2), .FIFO_DEPTH(8),
              .WORDS_PER_FRAME(16)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .vga_flag(vga_flag),
    .done_vga(done_vga), .vga_pixel(vga_pixel), .pix_req(pix_req),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .underflow(underflow),
    .frame_fetched(frame_fetched), .fifo_level(fifo_level));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [35:0] word(input int unsigned a);
    if (a == 0) return 36'h1_2345_6789;
    return {18'(32'h100 + 2 * a), 18'(32'h101 + 2 * a)};
  endfunction

  function automatic logic [17:0] exp_pix(input int unsigned i);
    logic [35:0] w;
    w = word(i / 2);
    return (i % 2 == 1) ? w[17:0] : w[35:18];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic fs, input logic dv, input logic pr);
    @(posedge clock); #1;
    frame_start = fs; done_vga = dv; pix_req = pr;
  endtask

  task automatic at_neg;
    @(negedge clock); #1;
  endtask

  // SRAM/arbiter model: a grant seen mid-cycle t is returned on vga_pixel during t+2.
  initial begin
    vga_pixel = '1;
    forever begin
      @(negedge clock);
      vga_pixel = s1;
      s1 = s0;
      if (reset || frame_start) begin
        a_cnt = 0; gcount = 0; s0 = '1;
      end else if (done_vga && vga_flag) begin
        s0 = word(a_cnt); a_cnt++; gcount++;
      end else begin
        s0 = '1;
      end
    end
  end

  // Monitor: pops one expected pixel per pixel_valid; occupancy must never exceed depth.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        total++;
        if (fifo_level > 4'd8) begin
          bad++;
          $display("FAIL overflow: fifo_level %0d exceeds 8", fifo_level);
        end
        if (pixel_valid) begin
          pix_seen++;
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL pixel: got %0h expected no pixel", pixel_out);
          end else begin
            e = expq.pop_front();
            if (pixel_out !== e) begin
              bad++;
              $display("FAIL pixel: got %0h expected %0h", pixel_out, e);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1; frame_start = 0; done_vga = 0; pix_req = 0;
    repeat (3) cyc(0, 0, 0);
    at_neg;
    chk("rst_vga_flag", vga_flag, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_frame_fetched", frame_fetched, 0);
    chk("rst_fifo_level", fifo_level, 0);

    // Fill: done_vga always high, no consumer -> credits stop at 8 grants.
    cyc(0, 1, 0); reset = 0;
    repeat (14) cyc(0, 1, 0);
    at_neg;
    chk("fill_grants", gcount, 8);
    chk("fill_vga_flag", vga_flag, 0);
    chk("fill_level", fifo_level, 8);

    // Unpack word0: upper half first, pop on the second pixel.
    cyc(0, 1, 1); expq.push_back(18'h048D1);
    cyc(0, 1, 1); expq.push_back(18'h16789);
    cyc(0, 1, 0);
    at_neg;
    chk("pop_level", fifo_level, 7);
    chk("pop_vga_flag", vga_flag, 1);
    repeat (6) cyc(0, 1, 0);
    at_neg;
    chk("refill_level", fifo_level, 8);
    chk("refill_grants", gcount, 9);
    idx = 2;

    // Drain words 1..8, then 20 requests into an empty FIFO.
    for (int i = 0; i < 36; i++) begin
      cyc(0, 0, 1);
      if (i < 16) begin expq.push_back(exp_pix(idx)); idx++; end
      else expq.push_back(18'h0);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    at_neg;
    chk("uf_underflow", underflow, 1);
    chk("uf_level", fifo_level, 0);
    repeat (15) cyc(0, 1, 0);
    at_neg;
    chk("frame_grants", gcount, 16);
    chk("frame_fetched", frame_fetched, 1);
    chk("frame_vga_flag", vga_flag, 0);
    chk("frame_level", fifo_level, 7);
    cyc(0, 0, 1); expq.push_back(18'h00112);
    cyc(0, 0, 0);

    cyc(1, 0, 0);
    cyc(0, 0, 0);
    at_neg;
    chk("fs1_level", fifo_level, 0);
    chk("fs1_underflow", underflow, 0);
    chk("fs1_frame_fetched", frame_fetched, 0);
    chk("fs1_grants", gcount, 0);

    // frame_start with 5 buffered and 2 in flight.
    cyc(0, 0, 1); expq.push_back(18'h0);
    cyc(0, 0, 0);
    at_neg;
    chk("fs2_underflow_set", underflow, 1);
    repeat (7) cyc(0, 1, 0);
    at_neg;
    chk("fs2_grants", gcount, 7);
    cyc(1, 0, 0);
    at_neg;
    chk("fs2_level_before", fifo_level, 5);
    chk("fs2_vga_flag_pulse", vga_flag, 0);
    cyc(0, 0, 0);
    at_neg;
    chk("fs2_level_after", fifo_level, 0);
    chk("fs2_underflow_clr", underflow, 0);
    chk("fs2_vga_flag_after", vga_flag, 1);
    cyc(0, 0, 0);
    at_neg;
    chk("fs2_level_discard", fifo_level, 0);

    // Full frame stream; k=7 has grant, push and pop together (level 5, 2 in flight).
    pix_seen = 0;
    idx = 0;
    for (int k = 0; k < 9; k++) begin
      cyc(0, 1, (k == 6 || k == 7));
      if (k == 6 || k == 7) begin expq.push_back(exp_pix(idx)); idx++; end
    end
    at_neg;
    chk("same_cycle_level", fifo_level, 5);
    for (int n = 0; n < 400 && idx < 32; n++) begin
      @(posedge clock); #1;
      frame_start = 0; done_vga = 1;
      pix_req = (fifo_level != 4'd0);
      if (pix_req) begin expq.push_back(exp_pix(idx)); idx++; end
    end
    chk("stream_drained", idx, 32);
    repeat (20) cyc(0, 1, 0);
    at_neg;
    chk("stream_grants", gcount, 16);
    chk("stream_fetched", frame_fetched, 1);
    chk("stream_vga_flag", vga_flag, 0);
    chk("stream_underflow", underflow, 0);
    chk("stream_level", fifo_level, 0);
    chk("stream_pixels", pix_seen, 32);
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
